// File: rtl/jam_cost_table.sv
// 8x8 cost matrix: row-major stream load with running sum of row minima, then zero-latency (W,J) lookup.
// Loads one word per cycle while LD_READY; no load backpressure in SERVE (LD_READY=0); RELOAD restarts.
module jam_cost_table #(
  parameter int COST_W = 7
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LD_VALID,
  input  logic [COST_W-1:0] LD_DATA,
  output logic              LD_READY,
  input  logic              RELOAD,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic              TABLE_RDY,
  output logic [COST_W+2:0] MIN_BOUND
);

  typedef enum logic {LOAD, SERVE} state_t;

  localparam logic [COST_W-1:0] ALL_ONES = {COST_W{1'b1}};

  state_t            state_q, state_d;
  logic [5:0]        addr_q, addr_d;
  logic [COST_W-1:0] row_min_q, row_min_d;
  logic [COST_W+2:0] bound_acc_q, bound_acc_d;
  logic [COST_W-1:0] mem [64];

  logic              accept;
  logic [COST_W-1:0] row_min_new;

  assign LD_READY    = (state_q == LOAD) & ~RELOAD;
  assign accept      = LD_VALID & LD_READY;
  assign row_min_new = (LD_DATA < row_min_q) ? LD_DATA : row_min_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    row_min_d   = row_min_q;
    bound_acc_d = bound_acc_q;
    if (RELOAD) begin
      state_d     = LOAD;
      addr_d      = 6'd0;
      row_min_d   = ALL_ONES;
      bound_acc_d = '0;
    end else if (accept) begin
      addr_d = addr_q + 6'd1;
      if (addr_q == 6'd63) begin
        state_d = SERVE;
      end
      // Column 7 closes the row: fold its minimum into the bound and rearm.
      if (addr_q[2:0] == 3'd7) begin
        bound_acc_d = bound_acc_q + {3'b000, row_min_new};
        row_min_d   = ALL_ONES;
      end else begin
        row_min_d = row_min_new;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= LOAD;
      addr_q      <= 6'd0;
      row_min_q   <= ALL_ONES;
      bound_acc_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_min_q   <= row_min_d;
      bound_acc_q <= bound_acc_d;
    end
  end

  // Storage is left unreset; stale entries are masked by Cost=0 outside SERVE.
  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[addr_q] <= LD_DATA;
    end
  end

  assign TABLE_RDY = (state_q == SERVE);
  assign Cost      = TABLE_RDY ? mem[{W, J}] : '0;
  assign MIN_BOUND = TABLE_RDY ? bound_acc_q : '0;

endmodule

// File: doc/jam_cost_table.md
# jam_cost_table

Cost-matrix responder for the job-assignment search engine. It loads an 8×8 worker/job cost matrix through a valid/ready stream, then answers the engine's per-cycle (W, J) queries with a zero-latency Cost. While loading, it also computes the sum of row minima (MIN_BOUND), a lower bound on any assignment cost that downstream pruning logic uses.

## Interface
- COST_W, 7, width of one cost entry; MIN_BOUND is COST_W+3 bits wide.
- N is fixed at 8 (3-bit indices, 64 entries) and is not a parameter.

- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- LD_VALID  in  1  load word present.
- LD_DATA  in  COST_W  cost entry, row-major order (W-major, J-minor).
- LD_READY  out  1  block accepts a load word this cycle.
- RELOAD  in  1  single-cycle pulse; discards the table and restarts loading.
- W  in  3  worker index of the query.
- J  in  3  job index of the query.
- Cost  out  COST_W  table[W][J].
- TABLE_RDY  out  1  table complete; queries valid.
- MIN_BOUND  out  COST_W+3  sum over rows of the minimum entry in each row.

## Operation
- State machine has two states: LOAD and SERVE. Reset enters LOAD.
- **Handshake**
  - LD_READY = (state==LOAD) & ~RELOAD, combinational.
  - A word is accepted on a rising edge where LD_VALID & LD_READY.
  - LD_DATA is don't-care when LD_VALID=0.
- **Addressing**
  - 6-bit addr register; row = addr[5:3], col = addr[2:0].
  - Each accepted word writes mem[addr], then addr increments.
  - Acceptance at addr=63 wraps addr to 0 and moves the state to SERVE.
- **Row-minimum tracking**
  - row_min register resets to all-ones (2^COST_W−1).
  - On acceptance with col≠7: row_min ← min(row_min, LD_DATA).
  - On acceptance with col=7: bound_acc ← bound_acc + min(row_min, LD_DATA), and row_min ← all-ones.
  - Width is sufficient, so bound_acc never overflows (8×127 = 1016 < 1024).
- **Outputs**
  - MIN_BOUND = bound_acc when TABLE_RDY=1, else 0.
  - SERVE: Cost = mem[{W,J}], combinational from W/J and memory; no clock latency.
  - LOAD: Cost = 0 regardless of W/J.
  - TABLE_RDY = (state==SERVE), registered.
- **RELOAD**
  - Any state: on the next edge, state←LOAD, addr←0, row_min←all-ones, bound_acc←0.
  - The word presented in the RELOAD cycle is dropped, because LD_READY is 0 that cycle.
  - mem is not cleared; stale contents are never visible because Cost=0 in LOAD.
- **Protocol**
  - LD_VALID in SERVE is ignored, since LD_READY=0.
  - A RELOAD pulse longer than one cycle holds the block in LOAD at addr 0.
- mem is a 64×COST_W register array with no reset; every other register is asynchronously reset.

## Timing
- Reset values: LD_READY=1, TABLE_RDY=0, Cost=0, MIN_BOUND=0, addr=0, row_min=all-ones, bound_acc=0.
- Minimum full load is 64 consecutive cycles.
- TABLE_RDY rises on the same edge that accepts word 63; Cost and MIN_BOUND are valid in that cycle.
- Query latency is 0. The engine updates W/J on an edge, and Cost must settle before the next edge.
- RELOAD sampled at edge k gives TABLE_RDY=0 and LD_READY=1 from edge k onward (RELOAD deasserted).
- RST_N falling mid-operation immediately forces the reset values above, independent of CLK.
- On release, LOAD resumes from addr 0.

## Test plan
- **Reset.** Assert RST_N=0 between edges → LD_READY=1, TABLE_RDY=0, Cost=0, MIN_BOUND=0 without waiting for a clock edge.
- **Basic load.** Continuous load with mem[w][j] = 8w+j → TABLE_RDY=1 after the 64th edge. W=3, J=5 → Cost=29. MIN_BOUND = 0+8+…+56 = 224. Sweeping all 64 (W,J) returns 8W+J.
- **Gapped load.** LD_VALID toggling every other cycle plus 3 extra valid words after completion → identical table and MIN_BOUND=224. Extra words are ignored (LD_READY=0) and W=0, J=0 still gives Cost=0.
- **Saturated entries.** All entries 127 → MIN_BOUND=1016 and Cost=127 everywhere. A reversed table, where each row's minimum is 8w in column 7, also gives MIN_BOUND=224, checking the column-7 min path.
- **RELOAD mid-load.** RELOAD asserted together with LD_VALID at word 30 → that word is dropped, TABLE_RDY stays 0 and Cost=0. A fresh 64-word load of all 5s gives MIN_BOUND=40 with no residue from the aborted load.
- **Reset and RELOAD in SERVE.** RST_N=0 in SERVE → TABLE_RDY=0 and Cost=0 immediately. A RELOAD pulse in SERVE gives TABLE_RDY=0 on the next edge and MIN_BOUND=0.
